// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction targets must be word aligned
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous prefetch FIFO with push/pop/flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pop on empty is ignored; push on full is blocked defensively
  assign push_ok = push && (count != CW'(DEPTH)) && !flush;
  assign pop_ok  = pop && (count != '0) && !flush;
  assign head    = mem[rd_ptr];

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush discards everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i fetch front end; optional FETCH_PERF_EN adds perf counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_opcode,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
`ifdef FETCH_PERF_EN
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_stall,
`endif
  output logic        o_fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t  state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   addr_q, addr_n;
  logic          fault_q, fault_n;
  logic          push, pop, flush;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] post_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;

  assign push_entry = '{pc: fetch_pc, instr: i_imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Head presentation: NOP and zero PC whenever nothing is buffered
  always_comb begin
    o_valid  = fifo_count != '0;
    o_opcode = o_valid ? fifo_head.instr : NOP_INSTR;
    o_pc     = o_valid ? fifo_head.pc : 32'h0;
  end

  assign o_imem_req    = (state == S_WAIT) || (state == S_DROP);
  assign o_imem_addr   = addr_q;
  assign o_fetch_fault = fault_q;

  // State register together with fetch PC, request address and fault flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_RUN;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      addr_q   <= addr_n;
      fault_q  <= fault_n;
    end
  end

  // Next-state, FIFO control and request address; redirect overrides everything
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = addr_q;
    fault_n    = fault_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = o_valid && i_ready && !i_redirect;
    post_count = fifo_count + CW'(1) - CW'(pop);

    if (i_redirect) begin
      // Anything in the FIFO or arriving this cycle belongs to the old path
      flush      = 1'b1;
      pop        = 1'b0;
      fetch_pc_n = i_redirect_addr;
      fault_n    = is_misaligned(i_redirect_addr);
      if (o_imem_req && !i_imem_ack) begin
        // Memory still owes us a response; absorb it before moving on
        state_n = S_DROP;
      end else if (is_misaligned(i_redirect_addr)) begin
        state_n = S_FAULT;
      end else begin
        state_n = S_WAIT;
        addr_n  = i_redirect_addr;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (fifo_count < DEPTH_C) begin
            state_n = S_WAIT;
            addr_n  = fetch_pc;
          end
        end
        S_WAIT: begin
          if (i_imem_ack) begin
            push       = 1'b1;
            fetch_pc_n = fetch_pc + 32'd4;
            if (post_count < DEPTH_C) begin
              addr_n = fetch_pc + 32'd4;
            end else begin
              state_n = S_RUN;
            end
          end
        end
        S_DROP: begin
          if (i_imem_ack) begin
            if (fault_q) begin
              state_n = S_FAULT;
            end else begin
              state_n = S_WAIT;
              addr_n  = fetch_pc;
            end
          end
        end
        S_FAULT: begin
          state_n = S_FAULT;
        end
        default: begin
          state_n = S_RUN;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: accepted fetches and downstream starvation cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_fetched <= 32'h0;
      o_perf_stall   <= 32'h0;
    end else begin
      if (push) begin
        o_perf_fetched <= o_perf_fetched + 32'd1;
      end
      if (!o_valid && i_ready) begin
        o_perf_stall <= o_perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
